pe_bitmap_encoder: RTL and testbench

//  Converts a DEPTH-bit bitmap (one-hot or multi-hot) into a serial stream of

---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_priority_encoder.sv | 23 ++
 rtl/pe_bitmap_encoder.sv | 88 ++++++++
 tb/tb_pe_bitmap_encoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE types and constants for the bitmap encoder / binary decoder pair.
package pe_pkg;

    // Index width shared between pe_bitmap_encoder and pe_binary_decoder.
    localparam int unsigned PE_ADDR_WIDTH = 3;

    // Encoder control states.
    typedef enum logic {
        PE_ENC_IDLE,
        PE_ENC_EMIT
    } pe_enc_state_e;

    // True when v has at most one bit set (x & (x - 1) == 0).
    function automatic logic pe_at_most_one_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/pe_priority_encoder.sv
// Combinational lowest-set-bit priority encoder.
module pe_priority_encoder #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic [DEPTH-1:0]      vec,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  found
);

    // Scan from the top down so the lowest set bit is the final assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = ADDR_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_bitmap_encoder.sv
// Serialises a bitmap into binary indices, lowest set bit first.
module pe_bitmap_encoder
    import pe_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PE_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DEPTH-1:0]      in_bitmap,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy
);

    pe_enc_state_e          state, state_nxt;
    logic [DEPTH-1:0]       pending, pending_nxt;
    logic [ADDR_WIDTH-1:0]  enc_idx;
    logic                   enc_found;
    logic                   single_bit;
    logic                   emitting;

    pe_priority_encoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_prio (
        .vec   (pending),
        .idx   (enc_idx),
        .found (enc_found)
    );

    // Exactly one pending bit left means the current index is the final one.
    always_comb begin
        single_bit = enc_found && ((pending & (pending - DEPTH'(1))) == '0);
    end

    // Output decode; everything here depends only on state and pending flops.
    always_comb begin
        emitting  = (state == PE_ENC_EMIT);
        in_ready  = (state == PE_ENC_IDLE);
        out_valid = emitting;
        busy      = emitting;
        out_addr  = (emitting && enc_found) ? enc_idx : '0;
        out_last  = emitting && single_bit;
    end

    // Next-state and pending update.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            PE_ENC_IDLE: begin
                if (in_valid && (in_bitmap != '0)) begin
                    pending_nxt = in_bitmap;
                    state_nxt   = PE_ENC_EMIT;
                end
            end
            PE_ENC_EMIT: begin
                if (out_ready) begin
                    pending_nxt = pending & ~(DEPTH'(1) << enc_idx);
                    if (single_bit) begin
                        state_nxt = PE_ENC_IDLE;
                    end
                end
            end
            default: begin
                state_nxt   = PE_ENC_IDLE;
                pending_nxt = '0;
            end
        endcase
    end

    // State and pending registers; reset discards any stream in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PE_ENC_IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_pe_bitmap_encoder.sv
// Directed self-checking bench for pe_bitmap_encoder.
module tb_pe_bitmap_encoder;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_bitmap;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;

    int n_checks;
    int n_pass;

    pe_bitmap_encoder #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bitmap (in_bitmap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [AW-1:0] a, input logic l);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".addr"},  32'(out_addr),  32'(a));
        chk({tag, ".last"},  32'(out_last),  32'(l));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk_out(tag, 1'b0, AW'(0), 1'b0);
    endtask

    initial begin
        logic [DW-1:0] acc;
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bitmap = '0;
        out_ready = 1'b0;
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: A4 with out_ready=1 -> 2, 5, 7(last)
        @(negedge clk);
        chk("t1.in_ready_pre", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_bitmap = 8'hA4; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("t1.i0", 1'b1, 3'd2, 1'b0);
        chk("t1.busy", 32'(busy), 32'd1);
        chk("t1.in_ready_emit", 32'(in_ready), 32'd0);
        @(negedge clk); chk_out("t1.i1", 1'b1, 3'd5, 1'b0);
        @(negedge clk); chk_out("t1.i2", 1'b1, 3'd7, 1'b1);
        @(negedge clk); chk_idle("t1.done");

        // 2: 14 with 3 cycles of backpressure
        in_valid = 1'b1; in_bitmap = 8'h14; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("t2.hold0", 1'b1, 3'd2, 1'b0);
        @(negedge clk); chk_out("t2.hold1", 1'b1, 3'd2, 1'b0);
        @(negedge clk); chk_out("t2.hold2", 1'b1, 3'd2, 1'b0);
        out_ready = 1'b1;
        @(negedge clk); chk_out("t2.i1", 1'b1, 3'd4, 1'b1);
        @(negedge clk); chk_idle("t2.done");

        // 3: FF -> 0..7, decoded indices OR back to FF
        in_valid = 1'b1; in_bitmap = 8'hFF;
        acc = '0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("t3.i%0d", i), 1'b1, AW'(i), (i == 7));
            if (out_valid) acc = acc | (DW'(1) << out_addr);
            @(negedge clk);
        end
        chk("t3.decode_or", 32'(acc), 32'hFF);
        chk_idle("t3.done");

        // 4: 00 dropped, then 80 accepted the next cycle
        in_valid = 1'b1; in_bitmap = 8'h00;
        @(negedge clk);
        chk_idle("t4.zero");
        in_bitmap = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("t4.i0", 1'b1, 3'd7, 1'b1);
        @(negedge clk); chk_idle("t4.done");

        // 5: reset mid-stream of 0F after index 1 consumed
        in_valid = 1'b1; in_bitmap = 8'h0F;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("t5.i0", 1'b1, 3'd0, 1'b0);
        @(negedge clk); chk_out("t5.i1", 1'b1, 3'd1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5.rst_valid", 32'(out_valid), 32'd0);
        chk("t5.rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); chk_idle("t5.post0");
        @(negedge clk); chk_idle("t5.post1");

        // 6: new bitmap held during EMIT of 06 is not captured early
        in_valid = 1'b1; in_bitmap = 8'h06;
        @(negedge clk);
        in_bitmap = 8'h01;
        chk_out("t6.i0", 1'b1, 3'd1, 1'b0);
        chk("t6.in_ready0", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_out("t6.i1", 1'b1, 3'd2, 1'b1);
        chk("t6.in_ready1", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_idle("t6.gap");
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("t6.j0", 1'b1, 3'd0, 1'b1);
        @(negedge clk); chk_idle("t6.done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
